chaotic_iter_driver: RTL and testbench

- Initiator/consumer end of the chaotic-system iteration handshake: calcu_ctrl out; busy, n1_valid, xn1/yn1/zn1 in.
- Issues one calcu_ctrl pulse per iteration and waits for the result.
- Discards the first SKIP_COUNT transient iterations.
- Folds each later state triple into an OUT_WIDTH word and buffers it in a FIFO drained by a valid/ready sink, e.g. the M-sequence scrambler.

---
 rtl/chaotic_iter_driver.sv | 208 ++++++++++++++++++++
 tb/tb_chaotic_iter_driver.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chaotic_iter_driver.sv
// chaotic_iter_driver: drives the chaotic-system iteration handshake and
// turns each post-transient state triple into a FIFO-buffered output word.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   enable              level; allows new iterations to be issued
//   calcu_ctrl          registered one-cycle iteration request pulse
//   busy                iteration block busy; blocks issue while high
//   n1_valid            one-cycle result strobe from the iteration block
//   xn1, yn1, zn1       iteration results (raw bits)
//   out_valid           FIFO not empty
//   out_ready           sink accepts out_data
//   out_data            FIFO head word (show-ahead)
//   fifo_level          FIFO occupancy
//   skip_done           all transient iterations have been discarded
//   err_timeout         sticky: an iteration never returned a result
module chaotic_iter_driver #(
   parameter int DATA_WIDTH = 64,
   parameter int OUT_WIDTH  = 8,
   parameter int BIT_LSB    = 0,
   parameter int DEPTH      = 4,
   parameter int SKIP_COUNT = 16,
   parameter int TIMEOUT    = 1023
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   output logic                    calcu_ctrl,
   input  logic                    busy,
   input  logic                    n1_valid,
   input  logic [DATA_WIDTH-1:0]   xn1,
   input  logic [DATA_WIDTH-1:0]   yn1,
   input  logic [DATA_WIDTH-1:0]   zn1,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_WIDTH-1:0]    out_data,
   output logic [$clog2(DEPTH):0]  fifo_level,
   output logic                    skip_done,
   output logic                    err_timeout
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = (SKIP_COUNT < 1) ? 1 : $clog2(SKIP_COUNT + 1);

   localparam logic [TW-1:0] TMR_LAST  = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] SKIP_LAST =
      SW'((SKIP_COUNT > 0) ? (SKIP_COUNT - 1) : 0);
   localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
   localparam logic          SKIP_INIT = (SKIP_COUNT == 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PULSE,
      S_WAIT
   } state_t;

   state_t          state_q, state_d;
   logic            calcu_ctrl_q, calcu_ctrl_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [SW-1:0]   skip_cnt_q, skip_cnt_d;
   logic            skip_done_q, skip_done_d;
   logic            err_q, err_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;

   logic [OUT_WIDTH-1:0] fifo_mem_q [DEPTH];

   logic                 issue_ok;
   logic                 in_wait;
   logic                 capture;
   logic                 tmr_expired;
   logic                 push;
   logic                 pop;
   logic [OUT_WIDTH-1:0] word;
   logic                 unused_bits;

   assign word = xn1[BIT_LSB +: OUT_WIDTH]
               ^ yn1[BIT_LSB +: OUT_WIDTH]
               ^ zn1[BIT_LSB +: OUT_WIDTH];

   // Only a slice of each state word feeds the output.
   assign unused_bits = ^{xn1, yn1, zn1};

   // Once transients are skipped, every capture pushes unconditionally,
   // so issue must be held off until a free slot is guaranteed.
   assign issue_ok = enable & ~busy
                   & (~skip_done_q | (level_q < LVL_FULL));

   assign in_wait     = (state_q == S_WAIT);
   assign capture     = in_wait & n1_valid;
   assign tmr_expired = in_wait & ~n1_valid & (timer_q == TMR_LAST);

   assign push = capture & skip_done_q;
   assign pop  = (level_q != '0) & out_ready;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (issue_ok) begin
               state_d = S_PULSE;
            end
         end
         S_PULSE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (n1_valid || tmr_expired) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs, timer, skip counter and FIFO bookkeeping
   always_comb begin
      // Registered from the next state so the pulse lines up with PULSE.
      calcu_ctrl_d = (state_d == S_PULSE);

      timer_d = timer_q;
      if (state_q == S_PULSE) begin
         timer_d = '0;
      end else if (in_wait) begin
         timer_d = timer_q + TW'(1);
      end

      err_d = err_q | tmr_expired;

      skip_cnt_d  = skip_cnt_q;
      skip_done_d = skip_done_q;
      if (capture && !skip_done_q) begin
         skip_cnt_d = skip_cnt_q + SW'(1);
         if (skip_cnt_q == SKIP_LAST) begin
            skip_done_d = 1'b1;
         end
      end

      wr_ptr_d = wr_ptr_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end

      rd_ptr_d = rd_ptr_q;
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      level_d = level_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         calcu_ctrl_q <= 1'b0;
         timer_q      <= '0;
         skip_cnt_q   <= '0;
         skip_done_q  <= SKIP_INIT;
         err_q        <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
      end else begin
         calcu_ctrl_q <= calcu_ctrl_d;
         timer_q      <= timer_d;
         skip_cnt_q   <= skip_cnt_d;
         skip_done_q  <= skip_done_d;
         err_q        <= err_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
      end
   end

   // Storage needs no reset: stale entries are masked by level_q.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= word;
      end
   end

   assign calcu_ctrl  = calcu_ctrl_q;
   assign out_valid   = (level_q != '0);
   assign out_data    = out_valid ? fifo_mem_q[rd_ptr_q] : '0;
   assign fifo_level  = level_q;
   assign skip_done   = skip_done_q;
   assign err_timeout = err_q;

endmodule

// File: tb/tb_chaotic_iter_driver.sv
// tb_chaotic_iter_driver: directed bench for chaotic_iter_driver with a
// stub iteration block that answers a fixed latency after each pulse.
module tb_chaotic_iter_driver;

   localparam int DW  = 64;
   localparam int OW  = 8;
   localparam int DEP = 4;
   localparam int LAT = 5;

   logic          clk;
   logic          rst;
   logic          enable;
   logic          calcu_ctrl;
   logic          busy;
   logic          n1_valid;
   logic [DW-1:0] xn1, yn1, zn1;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_data;
   logic [2:0]    fifo_level;
   logic          skip_done;
   logic          err_timeout;

   // Stub / stimulus state
   logic          stub_en;
   logic          stub_valid;
   logic          stray_valid;
   logic          seq_mode;
   logic [7:0]    seq_byte;
   int            stub_cnt;
   logic [DW-1:0] tb_x, tb_y, tb_z;

   int            pulse_cnt;
   int            width_err;
   logic          prev_c;

   int            n_cmp;
   int            n_bad;

   typedef struct {
      logic [DW-1:0] x;
      logic [DW-1:0] y;
      logic [DW-1:0] z;
      logic [OW-1:0] exp;
   } vec_t;

   vec_t vecs [6];

   chaotic_iter_driver #(
      .DATA_WIDTH (DW),
      .OUT_WIDTH  (OW),
      .BIT_LSB    (0),
      .DEPTH      (DEP),
      .SKIP_COUNT (2),
      .TIMEOUT    (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .calcu_ctrl  (calcu_ctrl),
      .busy        (busy),
      .n1_valid    (n1_valid),
      .xn1         (xn1),
      .yn1         (yn1),
      .zn1         (zn1),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .fifo_level  (fifo_level),
      .skip_done   (skip_done),
      .err_timeout (err_timeout)
   );

   assign n1_valid = stub_valid | stray_valid;
   assign xn1 = seq_mode ? {56'b0, seq_byte} : tb_x;
   assign yn1 = seq_mode ? '0 : tb_y;
   assign zn1 = seq_mode ? '0 : tb_z;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Stub iteration block: strobe n1_valid LAT cycles after a pulse.
   initial begin
      stub_cnt   = 0;
      stub_valid = 1'b0;
      seq_byte   = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            stub_cnt   = 0;
            stub_valid = 1'b0;
         end else begin
            if (stub_valid && seq_mode) seq_byte = seq_byte + 8'h01;
            stub_valid = 1'b0;
            if (stub_cnt > 0) begin
               stub_cnt = stub_cnt - 1;
               if (stub_cnt == 0) stub_valid = stub_en;
            end else if (calcu_ctrl) begin
               stub_cnt = LAT;
            end
         end
      end
   end

   // Pulse monitor: counts pulses and flags any pulse wider than 1 cycle.
   initial begin
      pulse_cnt = 0;
      width_err = 0;
      prev_c    = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (calcu_ctrl) begin
            pulse_cnt = pulse_cnt + 1;
            if (prev_c) width_err = width_err + 1;
         end
         prev_c = calcu_ctrl;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_strobe(input int budget, input string tag);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!n1_valid && k < budget);
      if (!n1_valid) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got no n1_valid required one within %0d cycles",
                  tag, budget);
      end
   endtask

   task automatic wait_level(input int lvl, input int budget,
                             input string tag);
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (fifo_level != 3'(lvl) && k < budget);
      if (fifo_level != 3'(lvl)) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got level %0d required %0d", tag, fifo_level,
                  lvl);
      end
   endtask

   initial begin
      int base;
      int k;
      logic [7:0] exp_head;

      n_cmp = 0;
      n_bad = 0;

      vecs[0] = '{64'h12, 64'h34, 64'h56, 8'h70};
      vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 8'hFF};
      vecs[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h0, 8'h00};
      vecs[3] = '{64'h3FF0_0000_0000_0001, 64'h4000_0000_0000_0080,
                  64'hC000_0000_0000_0003, 8'h82};
      vecs[4] = '{64'hDEAD_BEEF_CAFE_F00D, 64'h1234_5678_9ABC_DEF0,
                  64'h0, 8'hFD};
      vecs[5] = '{64'hAB00, 64'hCD, 64'hCD00, 8'hCD};

      rst         = 1'b1;
      enable      = 1'b0;
      busy        = 1'b0;
      out_ready   = 1'b0;
      stub_en     = 1'b1;
      stray_valid = 1'b0;
      seq_mode    = 1'b0;
      tb_x        = 64'h1111_2222_3333_44A5;
      tb_y        = 64'h5555_6666_7777_880F;
      tb_z        = 64'h9999_AAAA_BBBB_CC00;

      // Reset state
      tick(3);
      check("rst_calcu", calcu_ctrl, 0);
      check("rst_valid", out_valid, 0);
      check("rst_data", out_data, 0);
      check("rst_level", fifo_level, 0);
      check("rst_err", err_timeout, 0);
      check("rst_skip", skip_done, 0);

      // Skip phase: two results dropped, third yields A5^0F^00 = AA
      rst       = 1'b0;
      enable    = 1'b1;
      out_ready = 1'b1;
      wait_strobe(20, "skip_s1");
      check("skip1_level", fifo_level, 0);
      check("skip1_done", skip_done, 0);
      tick(1);
      check("skip1_after_done", skip_done, 0);
      check("skip1_after_level", fifo_level, 0);
      wait_strobe(20, "skip_s2");
      check("skip2_done", skip_done, 0);
      tick(1);
      check("skip2_after_done", skip_done, 1);
      check("skip2_after_level", fifo_level, 0);
      check("skip2_after_valid", out_valid, 0);
      wait_strobe(20, "skip_s3");
      check("skip3_valid_pre", out_valid, 0);
      tick(1);
      check("skip3_valid", out_valid, 1);
      check("skip3_data", out_data, 8'hAA);

      // Table-driven extraction vectors
      for (int i = 0; i < 6; i++) begin
         tb_x = vecs[i].x;
         tb_y = vecs[i].y;
         tb_z = vecs[i].z;
         wait_strobe(20, "vec_strobe");
         tick(1);
         check($sformatf("vec%0d_valid", i), out_valid, 1);
         check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
      end

      // Back-pressure: exactly DEPTH pulses, then hold
      base = pulse_cnt;
      tick(1);
      out_ready = 1'b0;
      seq_mode  = 1'b1;
      exp_head  = 8'h00;
      tick(60);
      check("bp_pulses", pulse_cnt - base, 4);
      check("bp_level", fifo_level, 4);
      check("bp_head", out_data, exp_head);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      exp_head  = exp_head + 8'h01;
      check("bp_pop_level", fifo_level, 3);
      check("bp_pop_head", out_data, exp_head);
      tick(1);
      check("bp_next_pulse", calcu_ctrl, 1);
      wait_strobe(20, "bp_strobe");
      tick(1);
      check("bp_refill", fifo_level, 4);

      // Pop two, then push and pop on the same capture cycle
      for (int i = 0; i < 2; i++) begin
         out_ready = 1'b1;
         check("pp_pop_data", out_data, exp_head);
         exp_head = exp_head + 8'h01;
         tick(1);
      end
      out_ready = 1'b0;
      check("pp_level2", fifo_level, 2);
      wait_strobe(20, "pp_strobe");
      check("pp_level_cap", fifo_level, 2);
      check("pp_head_cap", out_data, exp_head);
      out_ready = 1'b1;
      exp_head  = exp_head + 8'h01;
      tick(1);
      check("pp_level_same", fifo_level, 2);

      // Drain in order across pointer wrap
      k = 0;
      while (exp_head < 8'd12 && k < 200) begin
         if (out_valid) begin
            check("order", out_data, exp_head);
            exp_head = exp_head + 8'h01;
         end
         tick(1);
         k++;
      end
      check("order_count", exp_head, 12);

      // Busy gating
      busy = 1'b1;
      base = pulse_cnt;
      tick(20);
      check("busy_no_pulse", pulse_cnt - base, 0);
      busy = 1'b0;
      tick(1);
      check("busy_first_pulse", calcu_ctrl, 1);

      // Timeout on this pulse
      stub_en = 1'b0;
      tick(1);
      check("to_pulse_width", calcu_ctrl, 0);
      tick(9);
      check("to_err_early", err_timeout, 0);
      tick(1);
      check("to_err_set", err_timeout, 1);
      tick(1);
      check("to_next_pulse", calcu_ctrl, 1);
      enable = 1'b0;
      tick(20);
      out_ready = 1'b0;
      check("to_idle_level", fifo_level, 0);
      stray_valid = 1'b1;
      tick(1);
      stray_valid = 1'b0;
      tick(3);
      check("stray_level", fifo_level, 0);
      check("stray_valid", out_valid, 0);
      check("err_sticky", err_timeout, 1);

      // Reset in WAIT with three words buffered
      seq_mode = 1'b0;
      stub_en  = 1'b1;
      enable   = 1'b1;
      wait_level(3, 100, "rw_fill");
      tick(2);
      rst = 1'b1;
      #1;
      check("rw_calcu", calcu_ctrl, 0);
      check("rw_valid", out_valid, 0);
      check("rw_level", fifo_level, 0);
      check("rw_skip", skip_done, 0);
      check("rw_err", err_timeout, 0);
      tick(2);
      tb_x = 64'h5A;
      tb_y = 64'h0;
      tb_z = 64'h0;
      rst  = 1'b0;
      wait_strobe(20, "rs_s1");
      wait_strobe(20, "rs_s2");
      tick(1);
      check("rs_skip_done", skip_done, 1);
      check("rs_level0", fifo_level, 0);
      wait_strobe(20, "rs_s3");
      tick(1);
      check("rs_valid", out_valid, 1);
      check("rs_data", out_data, 8'h5A);

      check("pulse_width", width_err, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
               n_bad);
      $finish;
   end

endmodule
